// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage between the PC register and decode
// Purpose: samples pc, issues one word fetch per instruction over a req/ack
//   handshake, holds the returned word for decode, and pulses pc_en when decode
//   accepts it. A redirect squashes the fetch in flight.
// Optional feature macro: FETCH_TIMEOUT_EN adds an ack timeout counter and a
//   sticky ERROR state. Without it fetch_err is tied 0.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   pc, redirect                 current PC and non-sequential load indication
//   imem_req, imem_addr          fetch request and word-aligned address
//   imem_ack, imem_rdata         single-cycle completion pulse and data
//   instr, instr_pc, instr_valid fetched word and its address, to decode
//   instr_ready                  decode accepts this cycle
//   pc_en                        PC register load enable (combinational)
//   fetch_err                    sticky timeout flag
module fetch_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              redirect,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              pc_en,
  output logic              fetch_err
);

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_FLUSH, S_HOLD, S_ERROR} state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             expired;
  logic             err_q;

  // The cycle being counted now is the last one allowed without an ack.
  assign expired   = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign fetch_err = err_q;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FLUSH, S_HOLD} state_t;

  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign fetch_err = 1'b0;
`endif

  state_t state;

  // Fetch addresses are always word aligned, so the low PC bits are dropped.
  logic unused_pc_lo;
  assign unused_pc_lo = ^pc[1:0];

  // Redirect beats ready: the PC is taking a branch target instead of pc+4.
  assign pc_en = (state == S_HOLD) && instr_ready && !redirect;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          imem_req  <= 1'b1;
          imem_addr <= {pc[ADDR_W-1:2], 2'b00};
          state     <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt  <= '0;
`endif
        end

        S_WAIT: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            if (!redirect) begin
              instr       <= imem_rdata;
              instr_pc    <= imem_addr;
              instr_valid <= 1'b1;
              state       <= S_HOLD;
            end else begin
              state <= S_IDLE;
            end
          end
`ifdef FETCH_TIMEOUT_EN
          else if (expired) begin
            imem_req <= 1'b0;
            err_q    <= 1'b1;
            state    <= S_ERROR;
          end
`endif
          else if (redirect) begin
            // Memory cannot abort, so keep requesting and drop the data later.
            state <= S_FLUSH;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
`ifdef FETCH_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end

        S_FLUSH: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= S_IDLE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (expired) begin
            imem_req <= 1'b0;
            err_q    <= 1'b1;
            state    <= S_ERROR;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end

        S_HOLD: begin
          if (redirect || instr_ready) begin
            instr_valid <= 1'b0;
            state       <= S_IDLE;
          end
        end

`ifdef FETCH_TIMEOUT_EN
        S_ERROR: begin
          state <= S_ERROR;
        end
`endif

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc;
  logic        redirect;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_en;
  logic        fetch_err;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .TIMEOUT_CYCLES(4),
    .ADDR_W        (32)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pc         (pc),
    .redirect   (redirect),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pc_en      (pc_en),
    .fetch_err  (fetch_err)
  );

  // Reference instruction memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset_n = 1'b0; redirect = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; redirect = 1'b0; imem_ack = 1'b0; imem_rdata = 32'hFFFF_FFFF;
    instr_ready = 1'b1; pc = 32'hFFFF_FFFC;
    cyc();
    cyc();
    vectors++; if ({imem_req, instr_valid, fetch_err} !== 3'b000) begin errors++;
      $display("FAIL reset_flags: got %b expected 000", {imem_req, instr_valid, fetch_err}); end
    vectors++; if (imem_addr !== 32'h0) begin errors++;
      $display("FAIL reset_addr: got %h expected 0", imem_addr); end
    vectors++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin errors++;
      $display("FAIL reset_instr: got %h/%h expected 0/0", instr, instr_pc); end
    vectors++; if (pc_en !== 1'b0) begin errors++;
      $display("FAIL reset_pc_en: got %b expected 0", pc_en); end
  endtask

  task automatic test_basic();
    reset_n = 1'b0; instr_ready = 1'b0;
    cyc();
    pc = 32'h0; reset_n = 1'b1;
    cyc();
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin errors++;
      $display("FAIL basic_req: got req=%b addr=%h valid=%b expected 1/0/0", imem_req, imem_addr, instr_valid); end
    imem_ack = 1'b1; imem_rdata = 32'h2008_0005; instr_ready = 1'b1;
    #1;
    vectors++; if (pc_en !== 1'b0) begin errors++;
      $display("FAIL basic_pc_en_wait: got %b expected 0", pc_en); end
    cyc();
    imem_ack = 1'b0;
    vectors++; if (instr_valid !== 1'b1 || instr !== 32'h2008_0005 || instr_pc !== 32'h0) begin errors++;
      $display("FAIL basic_instr: got v=%b %h@%h expected 1 20080005@0", instr_valid, instr, instr_pc); end
    vectors++; if (imem_req !== 1'b0 || pc_en !== 1'b1) begin errors++;
      $display("FAIL basic_hold: got req=%b pc_en=%b expected 0/1", imem_req, pc_en); end
    cyc();
    pc = 32'h4;
    vectors++; if (instr_valid !== 1'b0 || pc_en !== 1'b0) begin errors++;
      $display("FAIL basic_after: got valid=%b pc_en=%b expected 0/0", instr_valid, pc_en); end
  endtask

  task automatic test_wait_stall();
    logic [31:0] exp_d;
    exp_d = 32'h0;
    instr_ready = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++;
        $display("FAIL stall_req_%0d: got req=%b addr=%h expected 1/4", i, imem_req, imem_addr); end
      if (i == 3) begin
        exp_d = $urandom; imem_ack = 1'b1; imem_rdata = exp_d;
      end
      cyc();
      imem_ack = 1'b0; imem_rdata = $urandom;
    end
    vectors++; if (imem_req !== 1'b0) begin errors++;
      $display("FAIL stall_req_drop: got %b expected 0", imem_req); end
    for (int j = 0; j < 2; j++) begin
      vectors++; if (instr_valid !== 1'b1 || instr !== exp_d || instr_pc !== 32'h4 || pc_en !== 1'b0) begin errors++;
        $display("FAIL stall_hold_%0d: got v=%b %h@%h pc_en=%b expected 1 %h@4 0", j, instr_valid, instr, instr_pc, pc_en, exp_d); end
      cyc();
    end
    instr_ready = 1'b1;
    #1;
    vectors++; if (pc_en !== 1'b1 || instr !== exp_d) begin errors++;
      $display("FAIL stall_accept: got pc_en=%b instr=%h expected 1 %h", pc_en, instr, exp_d); end
    cyc();
    pc = 32'h8;
    vectors++; if (instr_valid !== 1'b0 || pc_en !== 1'b0) begin errors++;
      $display("FAIL stall_after: got valid=%b pc_en=%b expected 0/0", instr_valid, pc_en); end
  endtask

  task automatic test_redirect_wait();
    instr_ready = 1'b0;
    cyc();
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++;
      $display("FAIL rw_req: got req=%b addr=%h expected 1/8", imem_req, imem_addr); end
    redirect = 1'b1;
    cyc();
    redirect = 1'b0; pc = 32'h40;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++;
      $display("FAIL rw_flush_req: got req=%b addr=%h expected 1/8", imem_req, imem_addr); end
    cyc();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; instr_ready = 1'b1;
    #1;
    vectors++; if (pc_en !== 1'b0 || instr_valid !== 1'b0) begin errors++;
      $display("FAIL rw_flush_ack: got pc_en=%b valid=%b expected 0/0", pc_en, instr_valid); end
    cyc();
    imem_ack = 1'b0;
    vectors++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin errors++;
      $display("FAIL rw_discard: got valid=%b req=%b expected 0/0", instr_valid, imem_req); end
    cyc();
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0) begin errors++;
      $display("FAIL rw_refetch: got req=%b addr=%h valid=%b expected 1/40/0", imem_req, imem_addr, instr_valid); end
    imem_ack = 1'b1; imem_rdata = mem_word(32'h40);
    cyc();
    imem_ack = 1'b0;
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== mem_word(32'h40)) begin errors++;
      $display("FAIL rw_deliver: got v=%b %h@%h expected 1 %h@40", instr_valid, instr, instr_pc, mem_word(32'h40)); end
  endtask

  task automatic test_redirect_hold();
    instr_ready = 1'b1; redirect = 1'b1;
    #1;
    vectors++; if (pc_en !== 1'b0) begin errors++;
      $display("FAIL rh_pc_en: got %b expected 0", pc_en); end
    cyc();
    redirect = 1'b0; pc = 32'h100;
    vectors++; if (instr_valid !== 1'b0) begin errors++;
      $display("FAIL rh_valid: got %b expected 0", instr_valid); end
    cyc();
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++;
      $display("FAIL rh_refetch: got req=%b addr=%h expected 1/100", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid_fetch();
    reset_n = 1'b0;
    cyc();
    vectors++; if ({imem_req, instr_valid, fetch_err} !== 3'b000 || imem_addr !== 32'h0) begin errors++;
      $display("FAIL rm_flags: got %b addr=%h expected 000 0", {imem_req, instr_valid, fetch_err}, imem_addr); end
    vectors++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin errors++;
      $display("FAIL rm_instr: got %h@%h expected 0@0", instr, instr_pc); end
    reset_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; pc = 32'h206;
    cyc();
    imem_ack = 1'b0;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h204 || instr_valid !== 1'b0) begin errors++;
      $display("FAIL rm_fresh: got req=%b addr=%h valid=%b expected 1/204/0", imem_req, imem_addr, instr_valid); end
    imem_ack = 1'b1; imem_rdata = mem_word(32'h204);
    cyc();
    imem_ack = 1'b0;
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h204 || instr !== mem_word(32'h204)) begin errors++;
      $display("FAIL rm_deliver: got v=%b %h@%h expected 1 %h@204", instr_valid, instr, instr_pc, mem_word(32'h204)); end
    instr_ready = 1'b1;
    cyc();
  endtask

  task automatic test_timeout();
    reset_dut();
    pc = 32'h300; instr_ready = 1'b1;
    cyc();
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      vectors++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin errors++;
        $display("FAIL to_wait_%0d: got req=%b err=%b expected 1/0", i, imem_req, fetch_err); end
      cyc();
    end
    for (int i = 0; i < 6; i++) begin
      vectors++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc_en !== 1'b0) begin errors++;
        $display("FAIL to_error_%0d: got err=%b req=%b valid=%b pc_en=%b expected 1/0/0/0", i, fetch_err, imem_req, instr_valid, pc_en); end
      cyc();
    end
`else
    for (int i = 0; i < 20; i++) begin
      vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h300 || fetch_err !== 1'b0) begin errors++;
        $display("FAIL to_wait_%0d: got req=%b addr=%h err=%b expected 1/300/0", i, imem_req, imem_addr, fetch_err); end
      cyc();
    end
`endif
    reset_dut();
  endtask

  task automatic test_random();
    logic [31:0] pc_prev, req_addr, dlv_addr, dlv_data;
    logic        in_flight, squashed, exp_req, exp_valid, exp_en;
    int          lat, delivered;
    reset_dut();
    pc = $urandom; pc_prev = pc; req_addr = 32'h0; dlv_addr = 32'h0; dlv_data = 32'h0;
    in_flight = 1'b0; squashed = 1'b0; exp_req = 1'b0; exp_valid = 1'b0; lat = 0; delivered = 0;
    for (int c = 0; c < 2000 && delivered < 150; c++) begin
      vectors++; if (imem_req !== exp_req || instr_valid !== exp_valid || fetch_err !== 1'b0) begin errors++;
        $display("FAIL rnd_ctl c=%0d: got req=%b valid=%b err=%b expected %b/%b/0", c, imem_req, instr_valid, fetch_err, exp_req, exp_valid); end
      if (exp_valid) begin
        vectors++; if (instr !== dlv_data || instr_pc !== dlv_addr) begin errors++;
          $display("FAIL rnd_instr c=%0d: got %h@%h expected %h@%h", c, instr, instr_pc, dlv_data, dlv_addr); end
      end
      imem_ack = 1'b0; imem_rdata = $urandom;
      if (exp_req) begin
        if (!in_flight) begin
          in_flight = 1'b1; squashed = 1'b0; lat = $urandom_range(0, 3);
          req_addr = {pc_prev[31:2], 2'b00};
        end
        vectors++; if (imem_addr !== req_addr) begin errors++;
          $display("FAIL rnd_addr c=%0d: got %h expected %h", c, imem_addr, req_addr); end
        if (lat == 0) begin
          imem_ack = 1'b1; imem_rdata = mem_word(req_addr);
        end else begin
          lat--;
        end
      end
      redirect    = ($urandom_range(0, 4) == 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      if (exp_req && redirect) squashed = 1'b1;
      exp_en = exp_valid && instr_ready && !redirect;
      #1;
      vectors++; if (pc_en !== exp_en) begin errors++;
        $display("FAIL rnd_pc_en c=%0d: got %b expected %b", c, pc_en, exp_en); end
      // Expected port state after the coming edge.
      if (imem_ack && !squashed) begin
        exp_req = 1'b0; exp_valid = 1'b1;
        dlv_data = mem_word(req_addr); dlv_addr = req_addr; delivered++;
      end else if (exp_valid) begin
        exp_req = 1'b0;
        if (instr_ready || redirect) exp_valid = 1'b0;
      end else if (exp_req) begin
        exp_req = !imem_ack;
      end else begin
        exp_req = 1'b1;
      end
      if (imem_ack) in_flight = 1'b0;
      pc_prev = pc;
      cyc();
      if (redirect) pc = $urandom;
      else if (exp_en) pc = pc + 32'd4;
    end
    redirect = 1'b0; imem_ack = 1'b0;
    vectors++; if (delivered < 150) begin errors++;
      $display("FAIL rnd_progress: got %0d deliveries expected 150", delivered); end
  endtask

  initial begin
    reset_n = 1'b0; pc = 32'h0; redirect = 1'b0; imem_ack = 1'b0;
    imem_rdata = 32'h0; instr_ready = 1'b0;
    test_reset();
    test_basic();
    test_wait_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_reset_mid_fetch();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Consumes the current PC value and issues a word fetch to instruction memory over a req/ack handshake that tolerates variable memory latency.
- Latches the returned instruction with its PC and presents it to decode through a valid/ready handshake.
- Generates the PC register's load enable and squashes in-flight fetches on branch/jump redirect.

Parameters:
TIMEOUT_CYCLES, 16, max cycles waiting for imem_ack before error (used only with FETCH_TIMEOUT_EN)
ADDR_W, 32, address/PC width

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset
pc  input  ADDR_W  current PC register output
redirect  input  1  PC loading a non-sequential target this edge; squash current fetch
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_W  word-aligned fetch address
imem_ack  input  1  single-cycle pulse, imem_rdata valid
imem_rdata  input  32  instruction word from memory
instr  output  32  fetched instruction
instr_pc  output  ADDR_W  address instr was fetched from
instr_valid  output  1  instr/instr_pc valid for decode
instr_ready  input  1  decode accepts instr this cycle
pc_en  output  1  load enable for PC register (combinational)
fetch_err  output  1  sticky fetch timeout flag

Behaviour:
- Reset (reset_n low at rising edge):
  - state := IDLE.
  - imem_req, instr_valid, fetch_err := 0.
  - imem_addr, instr, instr_pc := 0.
  - Reset overrides every other input, including mid-fetch; a late imem_ack after reset is ignored.
- IDLE:
  - At the next edge: imem_req := 1 and imem_addr := {pc[ADDR_W-1:2], 2'b00}; go to WAIT.
  - redirect in IDLE has no effect; the next sample picks up the new pc.
- WAIT:
  - imem_req and imem_addr are held stable until ack.
  - imem_ack and no redirect: imem_req := 0, instr := imem_rdata, instr_pc := imem_addr, instr_valid := 1; go to HOLD.
  - imem_ack with redirect in the same cycle: data discarded, imem_req := 0; go to IDLE.
  - redirect without ack: go to FLUSH. imem_req stays high because memory cannot abort.
- FLUSH:
  - Wait for imem_ack; discard the data, imem_req := 0; go to IDLE.
  - Further redirects are ignored.
- HOLD:
  - instr_valid = 1; instr and instr_pc are stable.
  - pc_en = (state==HOLD) && instr_ready && !redirect.
  - On instr_ready without redirect: instr_valid := 0; go to IDLE. The PC loads pc+4 on the same edge.
  - On redirect (redirect wins over ready): instr_valid := 0, pc_en = 0; go to IDLE.
- pc_en is never high outside HOLD.
- Latency with zero-wait memory (ack in the first WAIT cycle): pc sampled in IDLE → instr_valid 2 edges later. Minimum 3 cycles per instruction.
- instr_pc always equals the address actually requested, including when pc[1:0] is nonzero (low bits forced 0).

Optional Feature:
- Macro: FETCH_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT/FLUSH and increments each cycle in WAIT/FLUSH without imem_ack.
  - On reaching TIMEOUT_CYCLES: imem_req := 0, fetch_err := 1; go to ERROR.
  - ERROR issues no requests, holds instr_valid = 0 and pc_en = 0, and is left only by reset.
  - An ack in the same cycle the count expires wins (normal completion).
- Not defined:
  - No counter and no ERROR state; WAIT/FLUSH wait indefinitely.
  - The fetch_err port is present and tied 0.

Test Plan:
- Reset, then pc=0x00000000, memory acks in the first WAIT cycle with 0x20080005, instr_ready=1 → imem_addr=0x0, instr_valid high 2 edges after reset release, instr=0x20080005, instr_pc=0x0, pc_en high exactly one cycle.
- pc=0x00000004, ack delayed 3 cycles, instr_ready held 0 for 2 cycles in HOLD → imem_req high for 4 cycles with imem_addr stable; instr held stable; pc_en low until ready, then one-cycle pulse.
- Request at pc=0x8, redirect in WAIT, ack 2 cycles later with 0xDEADBEEF, pc now 0x40 → instr_valid stays 0, no pc_en, next imem_addr=0x40.
- HOLD with instr_ready=1 and redirect=1 in the same cycle → pc_en=0, instr_valid falls, next fetch from the redirected pc.
- reset_n low during WAIT with ack arriving the cycle after → all outputs 0, ack ignored, fresh fetch of the current pc after release.
- With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, memory never acks → fetch_err=1 after 4 WAIT cycles, imem_req=0, no further requests until reset. Without the macro → imem_req stays high and fetch_err=0.
